uart_rx_gen: RTL and testbench
==============================

Name: uart_rx_gen

Overview:
Parametrised UART receiver and successor to the fixed 8N1 receiver. It supports configurable data width, parity mode and stop-bit count. Each bit is decided by 16x oversampling with a 3-sample majority vote, and the block reports framing and parity errors. It sits between the board RX pin and the core's MMIO UART register block; its output is a one-cycle valid pulse with data and error flags.

Parameters:
FREQ, 100000000, system clock frequency in Hz
BAUDRATE, 9600, line baud rate in baud
DATA_BITS, 8, data bits per frame; legal 5..9
PARITY, 0, parity mode: 0 none, 1 odd, 2 even
STOP_BITS, 1, stop bits per frame; legal 1 or 2
DIV_OS (localparam), FREQ/(BAUDRATE*16), clocks per oversample tick; elaboration error if < 1

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
RX_Serial  input  1  asynchronous serial line, idle high
rx_data  output  DATA_BITS  last received data word, LSB = first bit received
rx_valid  output  1  one-clk pulse: rx_data and the error flags are updated
frame_err  output  1  last frame had a stop bit decided 0
parity_err  output  1  last frame failed the parity check (always 0 when PARITY=0)
busy  output  1  high in any state other than IDLE

Behaviour:
- Input path: RX_Serial passes through a 2-flop synchronizer to produce rx_s. All decisions use rx_s only.
- Tick generator:
  - Counter 0..DIV_OS-1; a tick is emitted on wrap. Width is $clog2(DIV_OS)+1.
  - Counter is forced to 0 on entry to START, so ticks are phase-aligned to the start edge.
- Sample counter: 4 bits, 0..15, increments per tick and wraps to 0.
- Majority vote: rx_s is captured on sample counts 7, 8 and 9. The bit decision is the majority of those three and is taken on the count-9 tick.
- State advance: occurs on the count-15 tick, except after the last stop bit (see STOP).
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: rx_s==0 -> START; sample counter and tick counter cleared.
  - START: on the count-9 decision, if the bit is 1 -> IDLE (glitch rejected, no output). If 0, wait for count 15, then -> DATA with the bit index cleared.
  - DATA: shift the decided bit in LSB-first. After DATA_BITS bits -> PAR if PARITY!=0, else -> STOP.
  - PAR: the decided bit is XORed with the data XOR.
    - Odd mode: the result must be 1.
    - Even mode: the result must be 0.
    - Mismatch sets an internal perr.
  - STOP: each stop bit decided 0 sets an internal ferr.
    - On the count-9 decision of the last stop bit: the FSM goes to IDLE in the same cycle and the frame's outputs are registered.
    - Early return lets the receiver resync on the next start bit with up to half a bit of skew.
- Outputs:
  - rx_data, frame_err and parity_err update together with rx_valid=1 for exactly one clk, one clk after the final stop decision.
  - These values hold until the next frame completes.
  - Errored frames still pulse rx_valid.
- Reset values: rx_data=0, rx_valid=0, frame_err=0, parity_err=0, busy=0, FSM=IDLE, all counters 0, synchronizer flops=1.
- Reset mid-frame: abort the frame, produce no rx_valid, and keep the flags cleared.
- Line held low in IDLE after a frame: counts as a new start bit immediately.
- Total latency: last stop bit mid-point + 1 clk to rx_valid (plus 2 clk of synchronizer delay relative to the pin).

Optional Feature:
UART_RX_BREAK_DET_EN:
- When defined:
  - Extra output port break_det (1 bit, reset 0).
  - A frame whose data, parity and stop decisions are all 0 pulses break_det for one clk instead of rx_valid; rx_data and the flags are unchanged.
  - The FSM then enters a BREAK state, which returns to IDLE only after rx_s has been 1 for 16 consecutive ticks.
- When undefined: no port and no BREAK state; such a frame is reported as rx_data=0, frame_err=1 with rx_valid.

Test Plan:
- Setup: FREQ=32000000, BAUDRATE=1000000 (DIV_OS=2, 32 clk/bit) unless stated.
- 8N1: send 0xA5 -> exactly one rx_valid pulse, rx_data=0xA5, frame_err=0, parity_err=0, busy low after the pulse; pulse 1 clk (+sync) after the stop bit mid-point.
- PARITY=2, DATA_BITS=7: send 0x3C with correct even parity -> parity_err=0. Resend with the parity bit inverted -> rx_valid with rx_data=0x3C and parity_err=1.
- STOP_BITS=2: send 0x55 with the second stop bit driven 0 -> frame_err=1, rx_data=0x55. A following good frame 0x0F -> frame_err=0.
- Glitch: drive the line low for 10 clk (< half bit) then high -> no rx_valid; FSM back in IDLE; busy high during the glitch only.
- Back-to-back: 0x12 then 0x34 with no idle gap, line baud +2% off nominal -> two rx_valid pulses with correct data and no errors.
- Reset mid-frame: assert reset for 1 clk during data bit 4 -> no rx_valid; the next full frame 0xC3 is received correctly. With UART_RX_BREAK_DET_EN: 12 bit-times low -> one break_det pulse, no rx_valid, recovery after 16 ticks high.

Source files
------------

// File: rtl/uart_rx_gen.sv
// rtl/uart_rx_gen.sv - parametrised 16x-oversampled UART receiver; define UART_RX_BREAK_DET_EN for break_det
module uart_rx_gen #(
  parameter int FREQ      = 100000000,
  parameter int BAUDRATE  = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 RX_Serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
`ifdef UART_RX_BREAK_DET_EN
  output logic                 break_det,
`endif
  output logic                 busy
);

  localparam int DIV_OS = FREQ / (BAUDRATE * 16);
  localparam int TW     = $clog2(DIV_OS) + 1;

  generate
    if (DIV_OS < 1) begin : g_div_check
      $error("uart_rx_gen: FREQ/(BAUDRATE*16) must be at least 1");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_db_check
      $error("uart_rx_gen: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_par_check
      $error("uart_rx_gen: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
      $error("uart_rx_gen: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
`ifdef UART_RX_BREAK_DET_EN
    , S_BREAK
`endif
  } state_t;

  state_t                 state;
  logic                   sync1;
  logic                   rx_s;
  logic [TW-1:0]          tick_cnt;
  logic                   tick;
  logic [3:0]             samp_cnt;
  logic                   s7;
  logic                   s8;
  logic                   vote;
  logic                   decide;
  logic                   advance;
  logic [3:0]             bit_idx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   dxor;
  logic                   perr;
  logic                   ferr;
  logic                   all_zero;
  logic                   ferr_nx;
  logic                   zero_nx;
`ifdef UART_RX_BREAK_DET_EN
  logic [3:0]             hi_cnt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= RX_Serial;
      rx_s  <= sync1;
    end
  end

  // Held at zero in IDLE so the first tick after a start edge is a full period away.
  assign tick = (tick_cnt == TW'(DIV_OS - 1));

  always_ff @(posedge clk) begin
    if (reset || state == S_IDLE || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign vote    = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
  assign decide  = tick && (samp_cnt == 4'd9);
  assign advance = tick && (samp_cnt == 4'd15);
  assign ferr_nx = ferr | ~vote;
  assign zero_nx = all_zero & ~vote;
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      samp_cnt   <= 4'd0;
      s7         <= 1'b1;
      s8         <= 1'b1;
      bit_idx    <= 4'd0;
      shreg      <= '0;
      dxor       <= 1'b0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      all_zero   <= 1'b1;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      break_det  <= 1'b0;
      hi_cnt     <= 4'd0;
`endif
    end else begin
      rx_valid <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      break_det <= 1'b0;
`endif
      if (tick) begin
        samp_cnt <= samp_cnt + 4'd1;
        if (samp_cnt == 4'd7) s7 <= rx_s;
        if (samp_cnt == 4'd8) s8 <= rx_s;
      end

      case (state)
        S_IDLE: begin
          samp_cnt <= 4'd0;
          if (!rx_s) begin
            state    <= S_START;
            bit_idx  <= 4'd0;
            dxor     <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            all_zero <= 1'b1;
          end
        end

        S_START: begin
          if (decide && vote) begin
            state <= S_IDLE;
          end else if (advance) begin
            state   <= S_DATA;
            bit_idx <= 4'd0;
          end
        end

        S_DATA: begin
          if (decide) begin
            shreg <= {vote, shreg[DATA_BITS-1:1]};
            dxor  <= dxor ^ vote;
            if (vote) all_zero <= 1'b0;
          end
          if (advance) begin
            if (bit_idx == 4'(DATA_BITS - 1)) begin
              bit_idx <= 4'd0;
              state   <= (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end

        S_PAR: begin
          if (decide) begin
            perr <= (PARITY == 1) ? ~(dxor ^ vote) : (dxor ^ vote);
            if (vote) all_zero <= 1'b0;
          end
          if (advance) begin
            state   <= S_STOP;
            bit_idx <= 4'd0;
          end
        end

        S_STOP: begin
          if (decide) begin
            if (bit_idx == 4'(STOP_BITS - 1)) begin
              // Return at mid-bit so a following start edge is never missed.
`ifdef UART_RX_BREAK_DET_EN
              if (zero_nx) begin
                state     <= S_BREAK;
                hi_cnt    <= 4'd0;
                break_det <= 1'b1;
              end else begin
                state      <= S_IDLE;
                rx_data    <= shreg;
                frame_err  <= ferr_nx;
                parity_err <= perr;
                rx_valid   <= 1'b1;
              end
`else
              state      <= S_IDLE;
              rx_data    <= shreg;
              frame_err  <= ferr_nx;
              parity_err <= perr;
              rx_valid   <= 1'b1;
`endif
            end else begin
              ferr     <= ferr_nx;
              all_zero <= zero_nx;
            end
          end else if (advance) begin
            bit_idx <= bit_idx + 4'd1;
          end
        end

`ifdef UART_RX_BREAK_DET_EN
        S_BREAK: begin
          if (tick) begin
            if (!rx_s) begin
              hi_cnt <= 4'd0;
            end else if (hi_cnt == 4'd15) begin
              state <= S_IDLE;
            end else begin
              hi_cnt <= hi_cnt + 4'd1;
            end
          end
        end
`endif

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_gen.sv
// tb/tb_uart_rx_gen.sv - randomized scoreboard bench for four uart_rx_gen configurations
`timescale 1ns/1ps
module tb_uart_rx_gen;
  localparam int FREQ = 32000000;
  localparam int BAUD = 1000000;
  localparam int NOM  = 3200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       reset_d = 1'b1;
  logic [3:0] line = 4'hF;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    reset_d <= reset;
  end

  logic [7:0] d0;
  logic [6:0] d1;
  logic [7:0] d2;
  logic [8:0] d3;
  logic [3:0] v, fe, pe, bz;
  logic [8:0] dq [4];
`ifdef UART_RX_BREAK_DET_EN
  logic [3:0] bd;
`endif

  always_comb begin
    dq[0] = {1'b0, d0};
    dq[1] = {2'b00, d1};
    dq[2] = {1'b0, d2};
    dq[3] = d3;
  end

  uart_rx_gen #(.FREQ(FREQ), .BAUDRATE(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset(reset), .RX_Serial(line[0]), .rx_data(d0), .rx_valid(v[0]),
    .frame_err(fe[0]), .parity_err(pe[0]),
`ifdef UART_RX_BREAK_DET_EN
    .break_det(bd[0]),
`endif
    .busy(bz[0]));
  uart_rx_gen #(.FREQ(FREQ), .BAUDRATE(BAUD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .reset(reset), .RX_Serial(line[1]), .rx_data(d1), .rx_valid(v[1]),
    .frame_err(fe[1]), .parity_err(pe[1]),
`ifdef UART_RX_BREAK_DET_EN
    .break_det(bd[1]),
`endif
    .busy(bz[1]));
  uart_rx_gen #(.FREQ(FREQ), .BAUDRATE(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u2 (
    .clk(clk), .reset(reset), .RX_Serial(line[2]), .rx_data(d2), .rx_valid(v[2]),
    .frame_err(fe[2]), .parity_err(pe[2]),
`ifdef UART_RX_BREAK_DET_EN
    .break_det(bd[2]),
`endif
    .busy(bz[2]));
  uart_rx_gen #(.FREQ(FREQ), .BAUDRATE(BAUD), .DATA_BITS(9), .PARITY(1), .STOP_BITS(1)) u3 (
    .clk(clk), .reset(reset), .RX_Serial(line[3]), .rx_data(d3), .rx_valid(v[3]),
    .frame_err(fe[3]), .parity_err(pe[3]),
`ifdef UART_RX_BREAK_DET_EN
    .break_det(bd[3]),
`endif
    .busy(bz[3]));

  int cfg_db[4]   = '{8, 7, 8, 9};
  int cfg_par[4]  = '{0, 2, 0, 1};
  int cfg_stop[4] = '{1, 1, 2, 1};

  typedef struct {
    int data;
    int perr;
    int ferr;
    int lo;
    int hi;
  } exp_t;

  exp_t expq [4][$];
  int   last_d [4];
  int   last_f [4];
  int   last_p [4];
  int   npulse [4];
  int   nbreak [4];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // Parity bit a correct transmitter sends: odd makes the total ones count odd.
  function automatic int par_bit(input int idx, input int data);
    int x;
    x = 0;
    for (int i = 0; i < cfg_db[idx]; i++) x ^= (data >> i) & 1;
    return (cfg_par[idx] == 1) ? (x ^ 1) : x;
  endfunction

  initial begin
    for (int i = 0; i < 4; i++) begin
      last_d[i] = 0; last_f[i] = 0; last_p[i] = 0; npulse[i] = 0; nbreak[i] = 0;
    end
  end

  always @(negedge clk) begin : cmp
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (reset_d) begin
        last_d[i] = 0; last_f[i] = 0; last_p[i] = 0;
      end
`ifdef UART_RX_BREAK_DET_EN
      if (bd[i]) nbreak[i]++;
`endif
      if (v[i]) begin
        npulse[i]++;
        if (expq[i].size() == 0) begin
          chk($sformatf("unexpected_valid_u%0d", i), 1, 0);
        end else begin
          e = expq[i].pop_front();
          chk($sformatf("data_u%0d", i), int'(dq[i]), e.data);
          chk($sformatf("perr_u%0d", i), int'(pe[i]), e.perr);
          chk($sformatf("ferr_u%0d", i), int'(fe[i]), e.ferr);
          chk($sformatf("latency_window_u%0d", i), int'(cyc >= e.lo && cyc <= e.hi), 1);
          last_d[i] = e.data; last_f[i] = e.perr == 0 ? e.ferr : e.ferr; last_p[i] = e.perr;
        end
      end else begin
        chk($sformatf("hold_data_u%0d", i), int'(dq[i]), last_d[i]);
        chk($sformatf("hold_ferr_u%0d", i), int'(fe[i]), last_f[i]);
        chk($sformatf("hold_perr_u%0d", i), int'(pe[i]), last_p[i]);
      end
      if (expq[i].size() > 0 && cyc > expq[i][0].hi) begin
        chk($sformatf("missing_valid_u%0d", i), 0, 1);
        void'(expq[i].pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame on line[idx]; per is the bit period in 1/100 clk.
  task automatic send(input int idx, input int data, input int pinv, input int stopz,
                      input int per, input int rst_at, input bit expect_frame);
    logic bits [16];
    int   nb;
    int   total;
    int   mid;
    int   slack;
    exp_t e;
    nb = 0;
    bits[nb] = 1'b0; nb++;
    for (int i = 0; i < cfg_db[idx]; i++) begin
      bits[nb] = 1'((data >> i) & 1); nb++;
    end
    if (cfg_par[idx] != 0) begin
      bits[nb] = 1'(par_bit(idx, data) ^ pinv); nb++;
    end
    for (int i = 0; i < cfg_stop[idx]; i++) begin
      bits[nb] = ((stopz >> i) & 1) != 0 ? 1'b0 : 1'b1; nb++;
    end
    total = (nb * per + 99) / 100;
    mid   = cyc + ((nb - 1) * per + per / 2) / 100;
    slack = (nb * ((per > NOM) ? per - NOM : NOM - per)) / 100;
    if (expect_frame) begin
      e.data = data;
      e.perr = (cfg_par[idx] != 0 && pinv != 0) ? 1 : 0;
      e.ferr = (stopz != 0) ? 1 : 0;
      e.lo   = mid - 4 - slack;
      e.hi   = mid + 10 + slack;
      expq[idx].push_back(e);
    end
    for (int c = 0; c < total; c++) begin
      line[idx] = bits[(c * 100) / per];
      reset = (c == rst_at);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    line[idx] = 1'b1;
  endtask

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int p;
    int idx, data, pinv, stopz, per, gap;
    reset = 1'b1;
    idle(4);
    @(negedge clk);
    chk("reset_valid", int'(v), 0);
    chk("reset_busy", int'(bz), 0);
    chk("reset_ferr", int'(fe), 0);
    chk("reset_perr", int'(pe), 0);
    chk("reset_data_u3", int'(dq[3]), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(5);

    chk("model_even_3c", par_bit(1, 'h3C), 0);
    chk("model_odd_1ff", par_bit(3, 'h1FF), 0);
    chk("model_odd_000", par_bit(3, 0), 1);

    p = npulse[0];
    send(0, 'hA5, 0, 0, NOM, -1, 1);
    idle(40);
    chk("a5_pulses", npulse[0] - p, 1);
    chk("a5_data", int'(dq[0]), 'hA5);
    chk("a5_busy_after", int'(bz[0]), 0);

    send(1, 'h3C, 0, 0, NOM, -1, 1);
    idle(20);
    chk("7e1_good_perr", int'(pe[1]), 0);
    send(1, 'h3C, 1, 0, NOM, -1, 1);
    idle(20);
    chk("7e1_bad_data", int'(dq[1]), 'h3C);
    chk("7e1_bad_perr", int'(pe[1]), 1);

    send(2, 'h55, 0, 2, NOM, -1, 1);
    idle(60);
    chk("8n2_stop2_ferr", int'(fe[2]), 1);
    chk("8n2_stop2_data", int'(dq[2]), 'h55);
    send(2, 'h0F, 0, 0, NOM, -1, 1);
    idle(40);
    chk("8n2_good_ferr", int'(fe[2]), 0);
    chk("8n2_good_data", int'(dq[2]), 'h0F);

    p = npulse[0];
    line[0] = 1'b0;
    idle(10);
    line[0] = 1'b1;
    chk("glitch_busy_high", int'(bz[0]), 1);
    idle(30);
    chk("glitch_busy_low", int'(bz[0]), 0);
    chk("glitch_no_valid", npulse[0] - p, 0);

    p = npulse[0];
    send(0, 'h12, 0, 0, 3137, -1, 1);
    send(0, 'h34, 0, 0, 3137, -1, 1);
    idle(40);
    chk("b2b_pulses", npulse[0] - p, 2);
    chk("b2b_last_data", int'(dq[0]), 'h34);

    p = npulse[0];
    send(0, 'hF0, 0, 0, NOM, 170, 0);
    idle(40);
    chk("rst_mid_no_valid", npulse[0] - p, 0);
    chk("rst_mid_data_clr", int'(dq[0]), 0);
    chk("rst_mid_ferr_clr", int'(fe[0]), 0);
    send(0, 'hC3, 0, 0, NOM, -1, 1);
    idle(40);
    chk("after_rst_data", int'(dq[0]), 'hC3);

`ifdef UART_RX_BREAK_DET_EN
    p = npulse[0];
    line[0] = 1'b0;
    idle(12 * 32);
    line[0] = 1'b1;
    idle(20);
    chk("break_busy_hold", int'(bz[0]), 1);
    idle(30);
    chk("break_recovered", int'(bz[0]), 0);
    chk("break_pulses", nbreak[0], 1);
    chk("break_no_valid", npulse[0] - p, 0);
    chk("break_data_kept", int'(dq[0]), 'hC3);
    send(0, 'h5A, 0, 0, NOM, -1, 1);
    idle(40);
`else
    send(0, 0, 0, 1, NOM, -1, 1);
    idle(60);
    chk("zero_frame_ferr", int'(fe[0]), 1);
    chk("zero_frame_data", int'(dq[0]), 0);
`endif

    for (int r = 0; r < 40; r++) begin
      idx   = $urandom_range(0, 3);
      data  = $urandom & ((1 << cfg_db[idx]) - 1);
      pinv  = (cfg_par[idx] != 0 && $urandom_range(0, 3) == 0) ? 1 : 0;
      stopz = 0;
      if (data != 0 && $urandom_range(0, 3) == 0)
        stopz = 1 << $urandom_range(0, cfg_stop[idx] - 1);
      case ($urandom_range(0, 2))
        0:       per = 3137;
        1:       per = 3264;
        default: per = NOM;
      endcase
      if (stopz != 0) per = NOM;
      gap = (stopz != 0) ? 60 : $urandom_range(0, 30);
      send(idx, data, pinv, stopz, per, -1, 1);
      idle(gap);
    end

    idle(80);
    for (int i = 0; i < 4; i++)
      chk($sformatf("queue_drained_u%0d", i), expq[i].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
